mmio_bridge: RTL and testbench
==============================

# mmio_bridge

Memory-mapped I/O bridge directly downstream of the CPU's external memory bus (`mem_a`/`mem_dout`/`mem_wr`/`mem_din`/`io_buffer_full`). It decodes every bus access to either the 128 KB RAM or the I/O window (`mem_a[17:16]==2'b11`). It buffers UART transmit and receive bytes in FIFOs, maintains the free-running cycle counter, and returns all read data with a fixed one-cycle latency, matching the CPU's memory contract.

## Interface
- `TX_DEPTH_LOG`, default 4: tx FIFO depth is 2^TX_DEPTH_LOG bytes.
- `RX_DEPTH_LOG`, default 3: rx FIFO depth is 2^RX_DEPTH_LOG bytes.
- `clk_in` input 1: single clock; every register samples on its rising edge.
- `rst_in` input 1: synchronous, active-high reset.
- `cpu_a` input 32: CPU address; only bits [17:0] are decoded.
- `cpu_dout` input 8: CPU write data.
- `cpu_wr` input 1: 1 = write, 0 = read.
- `cpu_din` output 8: read data, valid the cycle after the address.
- `io_buffer_full` output 1: tx FIFO nearly full.
- `ram_a` output 17: RAM address.
- `ram_we` output 1: RAM write enable.
- `ram_din` output 8: RAM write data.
- `ram_dout` input 8: RAM read data (synchronous, 1-cycle latency).
- `tx_data` output 8: byte offered to the UART transmitter.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: UART accepts the byte in the cycle where `tx_valid & tx_ready`.
- `rx_data` input 8: received byte.
- `rx_valid` input 1: 1-cycle strobe for `rx_data`.
- `program_end` output 1: sticky stop indication.
- `tx_overflow` output 1: sticky error flag.

## Operation
- Decode: `io_sel = cpu_a[17:16]==2'b11`. RAM path when `!io_sel`: `ram_a = cpu_a[16:0]`, `ram_din = cpu_dout`, `ram_we = cpu_wr & !io_sel`. All three are combinational.
- Write to 0x30000: push `cpu_dout` into the tx FIFO if it is nonzero. A write of 0x00 is ignored.
- Write to 0x30004: push 0x00 into the tx FIFO and set `end_pending`. `program_end` rises once `end_pending` is set, the tx FIFO is empty and no transfer is in flight. It stays high until reset.
- Read 0x30000: pop the rx FIFO and return its head byte. If the rx FIFO is empty, return 0x00 and do not pop.
- Read 0x30004: latch `snap <= cycle_cnt` and return `cycle_cnt[7:0]`. Reads of 0x30005, 0x30006 and 0x30007 return `snap[15:8]`, `snap[23:16]` and `snap[31:24]`. Other I/O addresses read 0x00, and writes to them are ignored.
- `cycle_cnt`: 32 bits, incremented every non-reset cycle, wraps modulo 2^32.
- Read-return mux uses a registered `sel_q`, one of {RAM, RX, CNT0, SNAP1, SNAP2, SNAP3, ZERO}, plus a registered `io_rdata_q`. `cpu_din = (sel_q==RAM) ? ram_dout : io_rdata_q`.
- tx side: `tx_valid = !tx_empty`, `tx_data` = FIFO head, pop on `tx_valid & tx_ready`. A push and a pop in the same cycle are both honoured and the count is unchanged.
- rx side: push on `rx_valid`. When the rx FIFO is full the incoming byte is dropped. Simultaneous push and pop are both honoured.
- `io_buffer_full = (tx_count >= 2^TX_DEPTH_LOG - 2)`. This leaves 2 slots of margin for writes already in flight.
- If a tx push arrives while the FIFO is truly full and no pop happens that cycle, the byte is dropped and `tx_overflow` is set (sticky).

## Timing
- Read latency is exactly 1 cycle for every address. Back-to-back reads to alternating RAM and I/O addresses return correct bytes each cycle.
- Writes take effect at the end of the issuing cycle; a tx push is visible on `tx_valid` the next cycle.
- Reset values:
  - FIFOs empty; `cycle_cnt=0`; `snap=0`; `sel_q=ZERO`; `io_rdata_q=0`.
  - `cpu_din=0`, `tx_valid=0`, `io_buffer_full=0`, `program_end=0`, `tx_overflow=0`, `end_pending=0`.
- Reset asserted mid-transfer discards all FIFO contents immediately; no byte is re-sent afterwards.
- FIFO pointers are TX/RX_DEPTH_LOG+1 bits wide. Wrap is natural. Empty means pointers are equal; full means the MSBs differ and the low bits are equal.

## Structure
- Shared package holds the I/O address constants (`IO_DATA=18'h30000`, `IO_CLK=18'h30004`) and the `sel_q` encoding.
- One sub-module: `sync_fifo` (parameters WIDTH and DEPTH_LOG; push/pop/full/empty/count). It is instantiated twice, once for tx and once for rx.

## Test plan
- Write 0x41, 0x00, 0x42 to 0x30000 with `tx_ready=1` → `tx_data` shows 0x41 then 0x42 only. `tx_overflow` stays 0.
- Hold `tx_ready=0` and write 16 bytes → `io_buffer_full` rises after the 14th push. The 17th write sets `tx_overflow`, and the FIFO still holds the first 16 bytes.
- At `cycle_cnt=0x12345678`, read 0x30004..0x30007 on consecutive cycles → `cpu_din` returns 0x78, 0x56, 0x34, 0x12, each one cycle after its address.
- Strobe `rx_data` 0x61 and 0x62, then read 0x30000 three times → returns 0x61, 0x62, 0x00.
- Write 0x55 to RAM 0x00100, then read RAM 0x00100 and IO 0x30000 back-to-back → `ram_we` is high only in the write cycle, and reads return 0x55 then the rx value.
- Write 0x30004 with `tx_ready=1` → `tx_data` sends 0x00, then `program_end` rises and stays high. Asserting `rst_in` clears it.

Source files
------------

// File: rtl/mmio_bridge_pkg.sv
// Shared definitions for the MMIO bridge: I/O register map and read-return select encoding.
package mmio_bridge_pkg;

    // I/O register map (18-bit decoded address space)
    localparam logic [17:0] IO_DATA  = 18'h30000;
    localparam logic [17:0] IO_CLK   = 18'h30004;
    localparam logic [17:0] IO_SNAP1 = 18'h30005;
    localparam logic [17:0] IO_SNAP2 = 18'h30006;
    localparam logic [17:0] IO_SNAP3 = 18'h30007;

    // Source of the byte returned on cpu_din one cycle after the address
    typedef enum logic [2:0] {
        SelRam,
        SelRx,
        SelCnt0,
        SelSnap1,
        SelSnap2,
        SelSnap3,
        SelZero
    } rd_sel_e;

    // The upper quarter of the 256 KB decoded window is I/O; everything else is RAM.
    function automatic logic is_io_addr(input logic [17:0] addr);
        return addr[17:16] == 2'b11;
    endfunction

endpackage

// File: rtl/mmio_bridge_sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; a push into a full FIFO is honoured only
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH_LOG = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DEPTH_LOG:0]   count_o
);

    localparam int unsigned Depth = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]   mem_q [Depth];
    logic [DEPTH_LOG:0] wr_ptr_q;
    logic [DEPTH_LOG:0] rd_ptr_q;
    logic               do_push;
    logic               do_pop;

    // Status flags and accepted handshakes
    always_comb begin
        empty_o = (wr_ptr_q == rd_ptr_q);
        full_o  = (wr_ptr_q[DEPTH_LOG] != rd_ptr_q[DEPTH_LOG]) &&
                  (wr_ptr_q[DEPTH_LOG-1:0] == rd_ptr_q[DEPTH_LOG-1:0]);
        count_o = wr_ptr_q - rd_ptr_q;
        do_pop  = pop_i & ~empty_o;
        // A full FIFO frees a slot in the same cycle it is popped
        do_push = push_i & (~full_o | do_pop);
        rdata_o = mem_q[rd_ptr_q[DEPTH_LOG-1:0]];
    end

    // Pointer registers; natural wrap of the extra MSB distinguishes full from empty
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[wr_ptr_q[DEPTH_LOG-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// CPU-side memory bus bridge: decodes RAM vs I/O, buffers UART bytes, keeps the cycle
// counter and returns every read with a fixed one-cycle latency.
module mmio_bridge
    import mmio_bridge_pkg::*;
#(
    parameter int unsigned TX_DEPTH_LOG = 4,
    parameter int unsigned RX_DEPTH_LOG = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_din,
    input  logic [7:0]  ram_dout,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_end,
    output logic        tx_overflow
);

    localparam int unsigned TxDepth = 1 << TX_DEPTH_LOG;
    // Two slots of margin for writes the CPU already has in flight
    localparam logic [TX_DEPTH_LOG:0] TxFullMark = (TX_DEPTH_LOG + 1)'(TxDepth - 2);

    logic [17:0]           addr;
    logic                  io_sel;

    logic                  tx_push;
    logic [7:0]            tx_wdata;
    logic                  tx_pop;
    logic                  tx_full;
    logic                  tx_empty;
    logic [TX_DEPTH_LOG:0] tx_count;

    logic                  rx_pop;
    logic [7:0]            rx_head;
    logic                  rx_full;
    logic                  rx_empty;
    logic [RX_DEPTH_LOG:0] rx_count;

    logic                  end_set;
    logic                  snap_load;
    rd_sel_e               sel_d;
    rd_sel_e               sel_q;
    logic [7:0]            io_rdata_d;
    logic [7:0]            io_rdata_q;
    logic [31:0]           cycle_cnt_q;
    logic [31:0]           snap_q;
    logic                  end_pending_q;
    logic                  program_end_q;
    logic                  tx_overflow_q;

    // RAM pass-through; the RAM sees every non-I/O access directly
    always_comb begin
        addr    = cpu_a[17:0];
        io_sel  = is_io_addr(addr);
        ram_a   = cpu_a[16:0];
        ram_din = cpu_dout;
        ram_we  = cpu_wr & ~io_sel;
    end

    // I/O access decode: tx pushes, rx pops, snapshot load and read-return selection
    always_comb begin
        tx_push    = 1'b0;
        tx_wdata   = cpu_dout;
        end_set    = 1'b0;
        rx_pop     = 1'b0;
        snap_load  = 1'b0;
        sel_d      = SelZero;
        io_rdata_d = 8'h00;
        if (cpu_wr) begin
            if (addr == IO_DATA) begin
                // Zero bytes are reserved as the end-of-program marker
                tx_push = (cpu_dout != 8'h00);
            end else if (addr == IO_CLK) begin
                tx_push  = 1'b1;
                tx_wdata = 8'h00;
                end_set  = 1'b1;
            end
        end else if (!io_sel) begin
            sel_d = SelRam;
        end else begin
            case (addr)
                IO_DATA: begin
                    sel_d      = SelRx;
                    rx_pop     = ~rx_empty;
                    io_rdata_d = rx_empty ? 8'h00 : rx_head;
                end
                IO_CLK: begin
                    sel_d      = SelCnt0;
                    snap_load  = 1'b1;
                    io_rdata_d = cycle_cnt_q[7:0];
                end
                IO_SNAP1: begin
                    sel_d      = SelSnap1;
                    io_rdata_d = snap_q[15:8];
                end
                IO_SNAP2: begin
                    sel_d      = SelSnap2;
                    io_rdata_d = snap_q[23:16];
                end
                IO_SNAP3: begin
                    sel_d      = SelSnap3;
                    io_rdata_d = snap_q[31:24];
                end
                default: begin
                    sel_d      = SelZero;
                    io_rdata_d = 8'h00;
                end
            endcase
        end
    end

    // Transmit handshake and status outputs
    always_comb begin
        tx_valid       = ~tx_empty;
        tx_pop         = tx_valid & tx_ready;
        io_buffer_full = (tx_count >= TxFullMark);
        cpu_din        = (sel_q == SelRam) ? ram_dout : io_rdata_q;
        program_end    = program_end_q;
        tx_overflow    = tx_overflow_q;
    end

    // Bridge state: counter, snapshot, read-return pipeline and sticky flags
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cycle_cnt_q   <= 32'h0;
            snap_q        <= 32'h0;
            sel_q         <= SelZero;
            io_rdata_q    <= 8'h00;
            end_pending_q <= 1'b0;
            program_end_q <= 1'b0;
            tx_overflow_q <= 1'b0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (snap_load) begin
                snap_q <= cycle_cnt_q;
            end
            sel_q      <= sel_d;
            io_rdata_q <= io_rdata_d;
            if (end_set) begin
                end_pending_q <= 1'b1;
            end
            // With no UART-side buffer, an empty FIFO means nothing is left in flight
            if (end_pending_q && tx_empty) begin
                program_end_q <= 1'b1;
            end
            if (tx_push && tx_full && !tx_pop) begin
                tx_overflow_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH     (8),
        .DEPTH_LOG (TX_DEPTH_LOG)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (tx_push),
        .wdata_i (tx_wdata),
        .pop_i   (tx_pop),
        .rdata_o (tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    sync_fifo #(
        .WIDTH     (8),
        .DEPTH_LOG (RX_DEPTH_LOG)
    ) u_rx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push_i  (rx_valid),
        .wdata_i (rx_data),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    // rx occupancy is not exported; keep the unused status visibly consumed
    logic unused_rx;
    assign unused_rx = ^{rx_full, rx_count, cpu_a[31:18]};

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed testbench for mmio_bridge with a small synchronous RAM model.
module tb_mmio_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        program_end;
    logic        tx_overflow;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] A_DATA = 32'h0003_0000;
    localparam logic [31:0] A_CLK  = 32'h0003_0004;
    localparam logic [31:0] A_IDLE = 32'h0003_0010;

    always #5 clk_in = ~clk_in;

    mmio_bridge #(
        .TX_DEPTH_LOG (4),
        .RX_DEPTH_LOG (3)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_we         (ram_we),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .program_end    (program_end),
        .tx_overflow    (tx_overflow)
    );

    // Synchronous RAM, one-cycle read latency
    logic [7:0] ram_mem [0:131071];
    always @(posedge clk_in) begin
        if (ram_we) ram_mem[ram_a] <= ram_din;
        ram_dout <= ram_mem[ram_a];
    end

    // Reference cycle counter
    logic [31:0] ref_cnt;
    always @(posedge clk_in) begin
        if (rst_in) ref_cnt <= 32'h0;
        else        ref_cnt <= ref_cnt + 32'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] a, input logic wr, input logic [7:0] d);
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
    endtask

    initial begin
        logic [31:0] snap_exp;
        logic        seen;

        rst_in   = 1'b1;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        set_bus(A_IDLE, 1'b0, 8'h00);
        tick();
        tick();
        tick();

        // Reset state
        check("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_buf_full", {31'h0, io_buffer_full}, 32'h0);
        check("rst_prog_end", {31'h0, program_end}, 32'h0);
        check("rst_overflow", {31'h0, tx_overflow}, 32'h0);

        // Counter starts at zero on the first cycle out of reset
        rst_in = 1'b0;
        set_bus(A_CLK, 1'b0, 8'h00);
        tick();
        check("cnt_first", {24'h0, cpu_din}, 32'h0);

        // tx: zero bytes are ignored
        tx_ready = 1'b1;
        set_bus(A_DATA, 1'b1, 8'h41);
        tick();
        check("tx_41_valid", {31'h0, tx_valid}, 32'h1);
        check("tx_41_data", {24'h0, tx_data}, 32'h41);
        set_bus(A_DATA, 1'b1, 8'h00);
        tick();
        check("tx_00_skipped", {31'h0, tx_valid}, 32'h0);
        set_bus(A_DATA, 1'b1, 8'h42);
        tick();
        check("tx_42_valid", {31'h0, tx_valid}, 32'h1);
        check("tx_42_data", {24'h0, tx_data}, 32'h42);
        set_bus(A_IDLE, 1'b0, 8'h00);
        tick();
        check("tx_drained", {31'h0, tx_valid}, 32'h0);
        check("tx_no_ovf", {31'h0, tx_overflow}, 32'h0);

        // tx fill: nearly-full at 14 entries, overflow on the 17th write
        tx_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_bus(A_DATA, 1'b1, 8'h10 + 8'(i));
            tick();
            check($sformatf("buf_full_%0d", i + 1), {31'h0, io_buffer_full},
                  (i + 1 >= 14) ? 32'h1 : 32'h0);
        end
        check("ovf_before_17", {31'h0, tx_overflow}, 32'h0);
        set_bus(A_DATA, 1'b1, 8'h99);
        tick();
        set_bus(A_IDLE, 1'b0, 8'h00);
        check("ovf_after_17", {31'h0, tx_overflow}, 32'h1);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_valid_%0d", i), {31'h0, tx_valid}, 32'h1);
            check($sformatf("drain_data_%0d", i), {24'h0, tx_data}, 32'h10 + i);
            tick();
        end
        check("drain_empty", {31'h0, tx_valid}, 32'h0);
        check("drain_not_full", {31'h0, io_buffer_full}, 32'h0);
        check("ovf_sticky", {31'h0, tx_overflow}, 32'h1);

        // Let the counter grow so the upper snapshot bytes are non-trivial
        repeat (66000) tick();

        // Counter snapshot read on consecutive cycles
        set_bus(A_CLK, 1'b0, 8'h00);
        snap_exp = ref_cnt;
        tick();
        check("cnt_b0", {24'h0, cpu_din}, {24'h0, snap_exp[7:0]});
        set_bus(A_CLK + 32'd1, 1'b0, 8'h00);
        tick();
        check("cnt_b1", {24'h0, cpu_din}, {24'h0, snap_exp[15:8]});
        set_bus(A_CLK + 32'd2, 1'b0, 8'h00);
        tick();
        check("cnt_b2", {24'h0, cpu_din}, {24'h0, snap_exp[23:16]});
        set_bus(A_CLK + 32'd3, 1'b0, 8'h00);
        tick();
        check("cnt_b3", {24'h0, cpu_din}, {24'h0, snap_exp[31:24]});
        set_bus(A_IDLE, 1'b0, 8'h00);
        repeat (300) tick();
        // Snapshot holds while the live counter moves on
        set_bus(A_CLK + 32'd1, 1'b0, 8'h00);
        tick();
        check("snap_held_b1", {24'h0, cpu_din}, {24'h0, snap_exp[15:8]});
        set_bus(32'h0003_0008, 1'b0, 8'h00);
        tick();
        check("io_other_rd", {24'h0, cpu_din}, 32'h0);
        set_bus(32'h0003_0008, 1'b1, 8'h5A);
        tick();
        set_bus(A_IDLE, 1'b0, 8'h00);
        check("io_other_wr", {31'h0, tx_valid}, 32'h0);

        // rx: two bytes, then an empty read
        rx_valid = 1'b1;
        rx_data  = 8'h61;
        tick();
        rx_data  = 8'h62;
        tick();
        rx_valid = 1'b0;
        set_bus(A_DATA, 1'b0, 8'h00);
        tick();
        check("rx_61", {24'h0, cpu_din}, 32'h61);
        tick();
        check("rx_62", {24'h0, cpu_din}, 32'h62);
        tick();
        check("rx_empty", {24'h0, cpu_din}, 32'h0);
        set_bus(A_IDLE, 1'b0, 8'h00);

        // rx overflow: ninth byte into an 8-deep FIFO is dropped
        rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rx_data = 8'h70 + 8'(i);
            tick();
        end
        rx_valid = 1'b0;
        set_bus(A_DATA, 1'b0, 8'h00);
        for (int i = 0; i < 9; i++) begin
            tick();
            check($sformatf("rx_full_%0d", i), {24'h0, cpu_din}, (i < 8) ? 32'h70 + i : 32'h0);
        end
        set_bus(A_IDLE, 1'b0, 8'h00);

        // RAM write, then RAM and I/O reads back-to-back
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        tick();
        rx_valid = 1'b0;
        set_bus(32'h0000_0100, 1'b1, 8'h55);
        #1;
        check("ram_we_wr", {31'h0, ram_we}, 32'h1);
        check("ram_a_wr", {15'h0, ram_a}, 32'h100);
        check("ram_din_wr", {24'h0, ram_din}, 32'h55);
        tick();
        set_bus(32'h0000_0100, 1'b0, 8'h00);
        #1;
        check("ram_we_rd", {31'h0, ram_we}, 32'h0);
        tick();
        set_bus(A_DATA, 1'b0, 8'h00);
        check("ram_rd_55", {24'h0, cpu_din}, 32'h55);
        #1;
        check("ram_we_io", {31'h0, ram_we}, 32'h0);
        tick();
        check("io_rd_77", {24'h0, cpu_din}, 32'h77);
        set_bus(32'h0003_0008, 1'b1, 8'h12);
        #1;
        check("ram_we_io_wr", {31'h0, ram_we}, 32'h0);
        tick();
        set_bus(A_IDLE, 1'b0, 8'h00);

        // End of program marker
        tx_ready = 1'b1;
        set_bus(A_CLK, 1'b1, 8'hAB);
        tick();
        set_bus(A_IDLE, 1'b0, 8'h00);
        check("end_tx_valid", {31'h0, tx_valid}, 32'h1);
        check("end_tx_zero", {24'h0, tx_data}, 32'h0);
        check("end_not_yet", {31'h0, program_end}, 32'h0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            seen = program_end;
        end
        check("end_rise", {31'h0, seen}, 32'h1);
        repeat (5) tick();
        check("end_sticky", {31'h0, program_end}, 32'h1);

        // Reset mid-transfer flushes the tx FIFO
        tx_ready = 1'b0;
        set_bus(A_DATA, 1'b1, 8'h31);
        tick();
        set_bus(A_DATA, 1'b1, 8'h32);
        tick();
        set_bus(A_IDLE, 1'b0, 8'h00);
        check("pre_rst_valid", {31'h0, tx_valid}, 32'h1);
        rst_in = 1'b1;
        tick();
        check("rst_flush_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_clears_end", {31'h0, program_end}, 32'h0);
        check("rst_clears_ovf", {31'h0, tx_overflow}, 32'h0);
        rst_in   = 1'b0;
        tx_ready = 1'b1;
        tick();
        tick();
        check("no_resend", {31'h0, tx_valid}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
